clk_rate_meter: RTL and testbench

CLK_RATE_METER -- requirements
Module: clk_rate_meter

---
 rtl/clk_rate_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 26 ++
 rtl/clk_rate_meter.sv | 125 ++++++++++++
 tb/tb_clk_rate_meter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rate_pkg.sv
// Shared types and default constants for the clock rate meter.
package clk_rate_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 26;
    localparam int DEF_TIMEOUT = 60000000;
    localparam int DEF_THRESH  = 1000000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge register; rise is a one-cycle pulse
// asserted two clk edges after the async input goes high.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_rate_meter.sv
// Measures the rising-to-rising period of a slow async signal in clk cycles.
// Define CLK_RATE_AVG4_EN to report a sliding average of the last 4 periods.
module clk_rate_meter
    import clk_rate_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             valid,
    output logic             is_fast,
    output logic             no_signal,
    output logic [1:0]       fsm_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, meas_val;
    logic             rise, meas, go_lost;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sig_in),
        .rise  (rise)
    );

    assign meas_val  = cnt_q + CNT_W'(1);
    assign fsm_state = state_q;

    // A detected edge always wins over the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        meas    = 1'b0;
        go_lost = 1'b0;
        case (state_q)
            IDLE, MEASURE: begin
                if (rise) begin
                    state_d = MEASURE;
                    meas    = (state_q == MEASURE);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOST;
                    go_lost = 1'b1;
                end
            end
            LOST:    if (rise) state_d = MEASURE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            no_signal <= 1'b0;
        end else begin
            state_q   <= state_d;
            no_signal <= (state_d == LOST);
            if (rise) cnt_q <= '0;
            else if (state_q != LOST && !go_lost) cnt_q <= meas_val;
        end
    end

    // valid is a single-cycle strobe with no back-pressure; period_out and
    // is_fast change only with it and hold otherwise.
`ifdef CLK_RATE_AVG4_EN
    logic [CNT_W-1:0] win_q [4];
    logic [CNT_W+1:0] sum_q, sum_d;
    logic [CNT_W-1:0] avg;
    logic [2:0]       n_q;

    // win_q[3] is the period leaving the window; zero until 4 are held.
    assign sum_d = sum_q + (CNT_W+2)'(meas_val) - (CNT_W+2)'(win_q[3]);
    assign avg   = sum_d[CNT_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
            sum_q      <= '0;
            n_q        <= '0;
            period_out <= '0;
            valid      <= 1'b0;
            is_fast    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (go_lost) begin
                for (int i = 0; i < 4; i++) win_q[i] <= '0;
                sum_q <= '0;
                n_q   <= '0;
            end else if (meas) begin
                win_q[0] <= meas_val;
                for (int i = 1; i < 4; i++) win_q[i] <= win_q[i-1];
                sum_q <= sum_d;
                if (n_q != 3'd4) n_q <= n_q + 3'd1;
                if (n_q >= 3'd3) begin
                    valid      <= 1'b1;
                    period_out <= avg;
                    is_fast    <= (avg < THRESH_C);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out <= '0;
            valid      <= 1'b0;
            is_fast    <= 1'b0;
        end else begin
            valid <= meas;
            if (meas) begin
                period_out <= meas_val;
                is_fast    <= (meas_val < THRESH_C);
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_rate_meter.sv
// Self-checking bench for clk_rate_meter, with an event-time reference model.
module tb_clk_rate_meter;

  localparam int CNT_W   = 26;
  localparam int TIMEOUT = 1000;
  localparam int THRESH  = 100;

`ifdef CLK_RATE_AVG4_EN
  localparam int P40_NV = 2, P40_FIRST = 162;
  localparam int AFTER400 = 310, AFTER100 = 175, AFTER1000 = 550, LOST_EDGE_P = 775;
  localparam int LOST_NV = 0, LOST_FIRST = -1, MID_NV = 0, MID_FIRST = -1;
  int seq_exp[$] = '{42, 44};
`else
  localparam int P40_NV = 5, P40_FIRST = 42;
  localparam int AFTER400 = 400, AFTER100 = 100, AFTER1000 = 1000, LOST_EDGE_P = 1000;
  localparam int LOST_NV = 3, LOST_FIRST = 42, MID_NV = 3, MID_FIRST = 42;
  int seq_exp[$] = '{40, 44, 40, 44, 48};
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             valid, is_fast, no_signal;
  logic [1:0]       fsm_state;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  clk_rate_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .THRESH(THRESH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period_out (period_out),
    .valid      (valid),
    .is_fast    (is_fast),
    .no_signal  (no_signal),
    .fsm_state  (fsm_state)
  );

  // ---------------- reference model ----------------
  // Works on event times: a rise first sampled at cycle k is acted on at k+2.
  int               cyc = 0;
  int               ref_cyc = 0;
  bit               fresh = 1'b1;
  bit               lost = 1'b0;
  bit               have_edge = 1'b0;
  logic             prev_s = 1'b0;
  int               det_q[$];
  int               win_q[$];
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_period = '0;
  logic             exp_fast = 1'b0;

  task automatic model_reset();
    det_q.delete();
    win_q.delete();
    exp_q.delete();
    fresh = 1'b1;
    lost = 1'b0;
    have_edge = 1'b0;
    prev_s = 1'b0;
    exp_period = '0;
    exp_fast = 1'b0;
  endtask

  task automatic model_tick();
    int per;
    logic [CNT_W-1:0] p;
    cyc++;
    exp_q.delete();
    if (fresh) begin
      ref_cyc = cyc - 1;
      fresh = 1'b0;
    end
    if (sig_in === 1'b1 && prev_s === 1'b0) det_q.push_back(cyc + 2);
    prev_s = sig_in;
    if (det_q.size() != 0 && det_q[0] == cyc) begin
      void'(det_q.pop_front());
      if (!lost && have_edge) begin
        per = cyc - ref_cyc;
`ifdef CLK_RATE_AVG4_EN
        win_q.push_back(per);
        if (win_q.size() > 4) void'(win_q.pop_front());
        if (win_q.size() == 4) begin
          p = CNT_W'((win_q[0] + win_q[1] + win_q[2] + win_q[3]) / 4);
          exp_q.push_back(p);
          exp_period = p;
          exp_fast = (p < THRESH);
        end
`else
        p = CNT_W'(per);
        exp_q.push_back(p);
        exp_period = p;
        exp_fast = (per < THRESH);
`endif
      end
      lost = 1'b0;
      have_edge = 1'b1;
      ref_cyc = cyc;
    end else if (!lost && (cyc - ref_cyc) == TIMEOUT) begin
      lost = 1'b1;
      win_q.delete();
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v);
    @(negedge clk);
    sig_in = v;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sig_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (period_out !== '0 || valid !== 1'b0 || is_fast !== 1'b0 || no_signal !== 1'b0 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL reset: period=%0d valid=%b fast=%b no_signal=%b state=%0d, want all 0", period_out, valid, is_fast, no_signal, fsm_state);
    end
    release_reset();
  endtask

  task automatic test_period_40();
    int nv = 0, first = -1, idx = 0;
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < 40; c++) begin
        step(c < 20);
        total++;
        if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
          bad++;
          $display("FAIL p40 cyc=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
        end
        if (valid === 1'b1) begin
          nv++;
          if (first < 0) first = idx;
          total++;
          if (period_out !== 40 || is_fast !== 1'b1) begin
            bad++;
            $display("FAIL p40_value: period=%0d fast=%b, want 40 1", period_out, is_fast);
          end
        end
        idx++;
      end
    total++;
    if (nv !== P40_NV || first !== P40_FIRST) begin
      bad++;
      $display("FAIL p40_timing: valids=%0d first=%0d, want %0d %0d", nv, first, P40_NV, P40_FIRST);
    end
  endtask

  task automatic test_slow_and_boundary();
    int pers[3] = '{400, 100, 1000};
    int want[3] = '{AFTER400, AFTER100, AFTER1000};
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < (s == 2 ? 3 : 4); p++)
        for (int c = 0; c < pers[s]; c++) begin
          step(c < pers[s] / 2);
          total++;
          if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
            bad++;
            $display("FAIL slow cyc=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
          end
        end
      total++;
      if (period_out !== CNT_W'(want[s]) || is_fast !== 1'b0 || no_signal !== 1'b0) begin
        bad++;
        $display("FAIL slow_end_%0d: period=%0d fast=%b no_signal=%b, want %0d 0 0", pers[s], period_out, is_fast, no_signal, want[s]);
      end
    end
  endtask

  task automatic test_lost();
    int nv_gap = 0, nv = 0, first = -1, clear_idx = -1;
    for (int i = 0; i < 1120; i++) begin
      step(i < 20);
      total++;
      if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
        bad++;
        $display("FAIL lost cyc=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
      end
      if (i == 2) begin
        total++;
        if (valid !== 1'b1 || period_out !== CNT_W'(LOST_EDGE_P)) begin
          bad++;
          $display("FAIL edge_vs_timeout: valid=%b period=%0d, want 1 %0d", valid, period_out, LOST_EDGE_P);
        end
      end
      if (i > 2 && valid === 1'b1) nv_gap++;
    end
    total++;
    if (no_signal !== 1'b1 || nv_gap !== 0) begin
      bad++;
      $display("FAIL lost_flag: no_signal=%b valids=%0d, want 1 0", no_signal, nv_gap);
    end
    for (int i = 0; i < 160; i++) begin
      step((i % 40) < 20);
      total++;
      if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
        bad++;
        $display("FAIL recover cyc=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
      end
      if (no_signal === 1'b0 && clear_idx < 0) clear_idx = i;
      if (valid === 1'b1) begin
        nv++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (clear_idx !== 2 || nv !== LOST_NV || first !== LOST_FIRST) begin
      bad++;
      $display("FAIL recover_timing: clear=%0d valids=%0d first=%0d, want 2 %0d %0d", clear_idx, nv, first, LOST_NV, LOST_FIRST);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0, first = -1;
    for (int i = 0; i < 100; i++) step((i % 40) < 20);
    @(negedge clk);
    rst_n = 1'b0;
    sig_in = 1'b0;
    model_reset();
    #1;
    total++;
    if (period_out !== '0 || valid !== 1'b0 || is_fast !== 1'b0 || no_signal !== 1'b0 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: period=%0d valid=%b fast=%b no_signal=%b state=%0d, want all 0", period_out, valid, is_fast, no_signal, fsm_state);
    end
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 160; i++) begin
      step((i % 40) < 20);
      total++;
      if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
        bad++;
        $display("FAIL after_reset cyc=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
      end
      if (valid === 1'b1) begin
        nv++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (nv !== MID_NV || first !== MID_FIRST) begin
      bad++;
      $display("FAIL after_reset_timing: valids=%0d first=%0d, want %0d %0d", nv, first, MID_NV, MID_FIRST);
    end
  endtask

  task automatic test_back_to_back();
    int pers[5] = '{40, 44, 40, 44, 48};
    logic [CNT_W-1:0] got[$];
    rst_n = 1'b0;
    sig_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < (p < 5 ? pers[p] : 6); c++) begin
        step(c < 3);
        total++;
        if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
          bad++;
          $display("FAIL b2b cyc=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
        end
        if (valid === 1'b1) got.push_back(period_out);
      end
    total++;
    if (got.size() !== seq_exp.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d valids, want %0d", got.size(), seq_exp.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        total++;
        if (got[i] !== CNT_W'(seq_exp[i])) begin
          bad++;
          $display("FAIL b2b_value[%0d]: period=%0d, want %0d", i, got[i], seq_exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int per, hi;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) per = $urandom_range(1001, 1150);
      else per = $urandom_range(4, 300);
      hi = $urandom_range(1, per - 1);
      for (int c = 0; c < per; c++) begin
        step(c < hi);
        total++;
        if (valid !== (exp_q.size() != 0) || no_signal !== lost || period_out !== exp_period || is_fast !== exp_fast) begin
          bad++;
          $display("FAIL random cyc=%0d per=%0d: valid=%b no_signal=%b period=%0d fast=%b, want %b %b %0d %b", cyc, per, valid, no_signal, period_out, is_fast, exp_q.size() != 0, lost, exp_period, exp_fast);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_period_40();
    test_slow_and_boundary();
    test_lost();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
